lyr1_conv_ctrl: RTL and testbench
=================================

# lyr1_conv_ctrl

Sequencer for the layer-1 3×3 MAC datapath. Accepts a raster-order pixel stream, builds 3×3 windows with two line buffers and drives the nine data operands, nine weights and bias onto the external single-cycle-registered MAC. It tracks results through the MAC pipeline stage and returns them in a 4-entry result FIFO with valid/ready backpressure. It sits between the input-image streamer and the layer-1 activation stage.

## Interface
- IMG_W, default 28: input image width in pixels (≥3).
- IMG_H, default 28: input image height in pixels (≥3).
- DW, default 16: pixel, weight and result width (MAC fixed-point format).
- clk, in, 1: clock; all logic is rising-edge.
- rst, in, 1: reset, asynchronous, active-low.
- start, in, 1: one-cycle pulse that begins a frame; honoured only in IDLE.
- cfg_we, in, 1: weight/bias write strobe; honoured only in IDLE.
- cfg_addr, in, 4: 0–8 selects w1–w9 (row-major window tap), 9 selects bias, 10–15 are ignored.
- cfg_data, in, DW: value to write.
- in_valid / in_ready, in / out, 1: pixel handshake.
- in_data, in, DW: pixel, raster order.
- mac_d, out, 9·DW: window taps, d1 in [DW-1:0], row-major (d1 = top-left, d9 = bottom-right).
- mac_w, out, 9·DW: w1..w9, same packing.
- mac_b, out, DW: bias.
- mac_res, in, DW: MAC result, valid one cycle after operands are presented.
- out_valid / out_ready, out / in, 1: result handshake.
- out_data, out, DW: result.
- busy, out, 1: high in RUN and DRAIN.
- done, out, 1: one-cycle pulse when a frame completes.

## Operation
- States are IDLE, RUN, DRAIN and DONE.
- IDLE→RUN on start. Column and row counters, line buffers and window registers clear on entry.
- RUN: accept pixel when in_valid && in_ready. col increments and wraps at IMG_W-1, at which point row increments.
  - Each accepted pixel shifts the window. The new column is formed from line buffer 1, line buffer 0 and in_data.
  - Both line buffers write at index col.
  - The window is valid when row≥2 && col≥2; this sets stage flag v_win.
- The last pixel (row = IMG_H-1, col = IMG_W-1) moves the FSM RUN→DRAIN. No further pixels are accepted (in_ready = 0).
- DRAIN→DONE when v_win = v_mac = 0 and the FIFO is empty. DONE lasts one cycle with done = 1, then goes to IDLE.
- Pipeline flags: v_win (operands on mac_d) moves to v_mac next cycle. When v_mac is set, mac_res is pushed into the FIFO.
- in_ready = (state==RUN) && (fifo_count + v_win + v_mac ≤ 3). Because of this, the FIFO never overflows and the MAC, which has no enable, never loses a result.
- Weights and bias are held in registers and drive mac_w/mac_b continuously. Writes in non-IDLE states are dropped.
- Arithmetic belongs to the MAC (truncating, wrap-around). The controller never alters values.
- Frame output count is (IMG_W-2)·(IMG_H-2), in raster order.
- start while busy is ignored. in_valid in IDLE or DRAIN is not accepted.
- Reset mid-frame forces IDLE, clears counters, flags, FIFO, weights and bias. Any partial frame is discarded.

## Timing
- Reset values are in_ready = 0, out_valid = 0, out_data = 0, mac_d = 0, mac_w = 0, mac_b = 0, busy = 0, done = 0.
- Pixel accepted in cycle t whose window is valid:
  - operands are on mac_d in t+1;
  - mac_res is valid in t+2 and written into the FIFO at the end of t+2;
  - out_valid is earliest at t+3.
- Throughput is one result per cycle when out_ready is held high.
- in_ready is registered-state based, not combinational on out_ready.
- A FIFO push and pop in the same cycle with count 4 is impossible by construction. Push and pop at any other count leave count unchanged.
- The done pulse comes on the cycle after the last result handshake completes.
- busy rises the cycle after start and falls with the done pulse.

## Structure
- Package lyr1_pkg holds:
  - the state enum (IDLE/RUN/DRAIN/DONE);
  - FX_ONE, fixed-point 1.0 in the MAC format;
  - CFG_BIAS_ADDR = 9;
  - RES_FIFO_DEPTH = 4.
- One sub-module, lyr1_res_fifo: synchronous 4-entry FIFO with count output and the same reset.
- Line buffers are inferred arrays inside lyr1_conv_ctrl.

## Test plan
- IMG_W = IMG_H = 4, w5 = FX_ONE, other weights and bias = 0, pixels 1..16 (as FX_ONE multiples), out_ready = 1 → out_data 6, 7, 10, 11 (×FX_ONE); done once; 4 results exactly.
- Same frame, all weights FX_ONE, bias = FX_ONE → results 55, 64, 91, 100 (×FX_ONE).
- out_ready low for 10 cycles during the frame → in_ready drops once FIFO plus in-flight reaches 4; no result lost or duplicated; order preserved.
- cfg_we and start pulses during RUN → ignored: weights unchanged, frame result identical to the undisturbed run.
- rst asserted mid-frame (after 7 pixels) → all outputs at reset values next cycle; new frame after reset produces correct 4 results once weights are reloaded.
- Back-to-back frames (start the cycle after done) with IMG_W = 5, IMG_H = 3 → 3 results per frame; counters and window restart cleanly; no cross-frame window mixing.

Source files
------------

// File: rtl/lyr1_pkg.sv
// Shared types and constants for the layer-1 3x3 convolution controller.
// The MAC format is Q8.8 for the default 16-bit datapath.
package lyr1_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int          FX_FRAC        = 8;
    localparam logic [15:0] FX_ONE         = 16'(1 << FX_FRAC);
    localparam logic [3:0]  CFG_BIAS_ADDR  = 4'd9;
    localparam int          RES_FIFO_DEPTH = 4;

endpackage

// File: rtl/lyr1_res_fifo.sv
// Small result FIFO between the MAC output and the activation stage.
// Exposes its occupancy so the sequencer can throttle pixel intake.
module lyr1_res_fifo
    import lyr1_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          valid_o,
    output logic [2:0]    count_o
);

    localparam int AW = $clog2(RES_FIFO_DEPTH);

    logic [DW-1:0] mem_q [RES_FIFO_DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [2:0]    count_q;
    logic          doPush;
    logic          doPop;

    assign doPop   = pop_i && (count_q != 3'd0);
    assign doPush  = push_i && (count_q != 3'(RES_FIFO_DEPTH));
    assign data_o  = mem_q[rdPtr_q];
    assign valid_o = (count_q != 3'd0);
    assign count_o = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RES_FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= data_i;
                wrPtr_q        <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/lyr1_conv_ctrl.sv
// Layer-1 3x3 convolution sequencer: builds raster windows from two line
// buffers, feeds the external MAC and queues its results for the next stage.
module lyr1_conv_ctrl
    import lyr1_pkg::*;
#(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int DW    = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            cfg_we,
    input  logic [3:0]      cfg_addr,
    input  logic [DW-1:0]   cfg_data,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_data,
    output logic [9*DW-1:0] mac_d,
    output logic [9*DW-1:0] mac_w,
    output logic [DW-1:0]   mac_b,
    input  logic [DW-1:0]   mac_res,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_data,
    output logic            busy,
    output logic            done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_t        state_q, state_d;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [DW-1:0] lineBuf0_q [IMG_W];
    logic [DW-1:0] lineBuf1_q [IMG_W];
    logic [DW-1:0] win_q      [9];
    logic [DW-1:0] weight_q   [9];
    logic [DW-1:0] bias_q;
    logic          vWin_q;
    logic          vMac_q;
    logic [2:0]    fifoCount;
    logic          accept;
    logic          lastPixel;
    logic          startFrame;

    assign accept     = in_valid && in_ready;
    assign lastPixel  = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
    assign startFrame = (state_q == IDLE) && start;
    // Reserve a FIFO slot for every result already in the MAC pipeline.
    assign in_ready   = (state_q == RUN) &&
                        (({1'b0, fifoCount} + 4'(vWin_q) + 4'(vMac_q)) <= 4'd3);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (accept && lastPixel) state_d = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (!vWin_q && !vMac_q && (fifoCount == 3'd0)) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q  <= '0;
            row_q  <= '0;
            vWin_q <= 1'b0;
            vMac_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else if (startFrame) begin
            col_q  <= '0;
            row_q  <= '0;
            vWin_q <= 1'b0;
            vMac_q <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            vWin_q <= accept && (row_q >= RW'(2)) && (col_q >= CW'(2));
            vMac_q <= vWin_q;
            if (accept) begin
                if (col_q == CW'(IMG_W - 1)) begin
                    col_q <= '0;
                    row_q <= (row_q == RW'(IMG_H - 1)) ? '0 : row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
                for (int r = 0; r < 3; r++) begin
                    win_q[3*r]   <= win_q[3*r+1];
                    win_q[3*r+1] <= win_q[3*r+2];
                end
                win_q[2] <= lineBuf1_q[col_q];
                win_q[5] <= lineBuf0_q[col_q];
                win_q[8] <= in_data;
            end
        end
    end

    // Line buffers hold the two previous rows; no reset needed since a frame start clears them.
    always_ff @(posedge clk) begin
        if (startFrame) begin
            for (int i = 0; i < IMG_W; i++) begin
                lineBuf0_q[i] <= '0;
                lineBuf1_q[i] <= '0;
            end
        end else if (accept) begin
            lineBuf1_q[col_q] <= lineBuf0_q[col_q];
            lineBuf0_q[col_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bias_q <= '0;
            for (int i = 0; i < 9; i++) begin
                weight_q[i] <= '0;
            end
        end else if ((state_q == IDLE) && cfg_we) begin
            if (cfg_addr < CFG_BIAS_ADDR) begin
                weight_q[cfg_addr] <= cfg_data;
            end else if (cfg_addr == CFG_BIAS_ADDR) begin
                bias_q <= cfg_data;
            end
        end
    end

    always_comb begin
        mac_d = '0;
        mac_w = '0;
        for (int i = 0; i < 9; i++) begin
            mac_d[i*DW +: DW] = win_q[i];
            mac_w[i*DW +: DW] = weight_q[i];
        end
    end

    assign mac_b = bias_q;

    lyr1_res_fifo #(.DW(DW)) u_res_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (vMac_q),
        .data_i  (mac_res),
        .pop_i   (out_ready),
        .data_o  (out_data),
        .valid_o (out_valid),
        .count_o (fifoCount)
    );

endmodule

// File: tb/tb_lyr1_conv_ctrl.sv
// Directed bench for lyr1_conv_ctrl: three frame geometries share one stimulus
// bus, a behavioural MAC closes the loop, and results are collected per frame.
`timescale 1ns/1ps
module tb_lyr1_conv_ctrl;
    import lyr1_pkg::*;

    localparam int DW = 16;

    logic clk;
    logic rst;
    logic start;
    logic cfgWe;
    logic [3:0] cfgAddr;
    logic [DW-1:0] cfgData;
    logic inValid;
    logic [DW-1:0] inData;
    logic outReady;

    logic inReadyV [3];
    logic outValidV [3];
    logic busyV [3];
    logic doneV [3];
    logic [DW-1:0] outDataV [3];
    logic [DW-1:0] macBV [3];
    logic [DW-1:0] macResV [3];
    logic [9*DW-1:0] macDV [3];
    logic [9*DW-1:0] macWV [3];

    int sel = 0;
    logic inReady, outValid, busySig, doneSig;
    logic [DW-1:0] outData, macB;
    logic [9*DW-1:0] macD, macW;

    assign inReady  = inReadyV[sel];
    assign outValid = outValidV[sel];
    assign busySig  = busyV[sel];
    assign doneSig  = doneV[sel];
    assign outData  = outDataV[sel];
    assign macB     = macBV[sel];
    assign macD     = macDV[sel];
    assign macW     = macWV[sel];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int doneCnt = 0;
    int firstValidCyc = -1;
    int acc [64];
    int expV [8];
    logic sawDrop;
    logic [DW-1:0] got [$];

    // 4x4 frame
    lyr1_conv_ctrl #(.IMG_W(4), .IMG_H(4), .DW(DW)) u_dut (
        .clk(clk), .rst(rst), .start(start), .cfg_we(cfgWe), .cfg_addr(cfgAddr),
        .cfg_data(cfgData), .in_valid(inValid), .in_ready(inReadyV[0]), .in_data(inData),
        .mac_d(macDV[0]), .mac_w(macWV[0]), .mac_b(macBV[0]), .mac_res(macResV[0]),
        .out_valid(outValidV[0]), .out_ready(outReady), .out_data(outDataV[0]),
        .busy(busyV[0]), .done(doneV[0]));

    // 5x3 frame
    lyr1_conv_ctrl #(.IMG_W(5), .IMG_H(3), .DW(DW)) u_dut53 (
        .clk(clk), .rst(rst), .start(start), .cfg_we(cfgWe), .cfg_addr(cfgAddr),
        .cfg_data(cfgData), .in_valid(inValid), .in_ready(inReadyV[1]), .in_data(inData),
        .mac_d(macDV[1]), .mac_w(macWV[1]), .mac_b(macBV[1]), .mac_res(macResV[1]),
        .out_valid(outValidV[1]), .out_ready(outReady), .out_data(outDataV[1]),
        .busy(busyV[1]), .done(doneV[1]));

    // 6x4 frame, enough results to fill the FIFO mid-frame
    lyr1_conv_ctrl #(.IMG_W(6), .IMG_H(4), .DW(DW)) u_dut64 (
        .clk(clk), .rst(rst), .start(start), .cfg_we(cfgWe), .cfg_addr(cfgAddr),
        .cfg_data(cfgData), .in_valid(inValid), .in_ready(inReadyV[2]), .in_data(inData),
        .mac_d(macDV[2]), .mac_w(macWV[2]), .mac_b(macBV[2]), .mac_res(macResV[2]),
        .out_valid(outValidV[2]), .out_ready(outReady), .out_data(outDataV[2]),
        .busy(busyV[2]), .done(doneV[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural single-cycle MAC in Q8.8 with wrap-around.
    function automatic logic [DW-1:0] macModel(input logic [9*DW-1:0] d,
                                               input logic [9*DW-1:0] w,
                                               input logic [DW-1:0] b);
        logic [31:0] sum;
        sum = 32'd0;
        for (int i = 0; i < 9; i++) begin
            sum = sum + ((32'(d[i*DW +: DW]) * 32'(w[i*DW +: DW])) >> FX_FRAC);
        end
        return DW'(sum) + b;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            macResV[k] <= macModel(macDV[k], macWV[k], macBV[k]);
        end
    end

    // Scoreboard collection, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst && outValid && outReady) got.push_back(outData);
        if (rst && doneSig) doneCnt++;
        if (rst && outValid && firstValidCyc < 0) firstValidCyc = cyc;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [9*DW-1:0] obs,
                               input logic [9*DW-1:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic writeCfg(input logic [3:0] a, input logic [DW-1:0] v);
        cfgWe = 1'b1;
        cfgAddr = a;
        cfgData = v;
        tick;
        cfgWe = 1'b0;
    endtask

    task automatic loadWeights(input logic centreOnly, input logic [DW-1:0] b);
        for (int i = 0; i < 9; i++) begin
            writeCfg(4'(i), (centreOnly && i != 4) ? '0 : FX_ONE);
        end
        writeCfg(CFG_BIAS_ADDR, b);
    endtask

    task automatic resetAll;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        tick;
    endtask

    // Runs one frame: pulse start, stream n pixels (base+i)*FX_ONE; optional stall/disturb/abort.
    task automatic applyStimulus(input int n, input int base, input int stallAt,
                                 input int stallLen, input int disturbAt, input int abortAt);
        int i = 0;
        int guard = 0;
        int stallLeft = 0;
        logic stalled = 1'b0;
        logic disturbed = 1'b0;
        got.delete();
        doneCnt = 0;
        firstValidCyc = -1;
        sawDrop = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        while (i < n && i != abortAt && guard < 2000) begin
            cfgWe = 1'b0;
            start = 1'b0;
            if (i == disturbAt && !disturbed) begin
                disturbed = 1'b1;
                cfgWe = 1'b1;
                cfgAddr = 4'd4;
                cfgData = 16'h1234;
                start = 1'b1;
            end
            if (i == stallAt && !stalled) begin
                stalled = 1'b1;
                outReady = 1'b0;
                stallLeft = stallLen;
            end else if (stallLeft > 0) begin
                stallLeft--;
                if (stallLeft == 0) outReady = 1'b1;
            end
            if (stallLeft > 0 && !inReady) sawDrop = 1'b1;
            inValid = 1'b1;
            inData = DW'((base + i) * FX_ONE);
            if (inReady) begin
                acc[i] = cyc;
                i++;
            end
            tick;
            guard++;
        end
        inValid = 1'b0;
        cfgWe = 1'b0;
        start = 1'b0;
        outReady = 1'b1;
        if (guard >= 2000) checkOutput("feed_budget", 144'(i), 144'(n));
    endtask

    task automatic expectResults(input string tag, input int n);
        int guard = 0;
        while (!doneSig && guard < 300) begin
            tick;
            guard++;
        end
        checkOutput({tag, "_done_seen"}, 144'(doneSig), 144'(1));
        tick;
        checkOutput({tag, "_count"}, 144'(got.size()), 144'(n));
        for (int k = 0; k < n; k++) begin
            checkOutput($sformatf("%s_r%0d", tag, k),
                        (k < got.size()) ? 144'(got[k]) : {144{1'bx}},
                        144'(expV[k] * FX_ONE));
        end
        checkOutput({tag, "_done_once"}, 144'(doneCnt), 144'(1));
        checkOutput({tag, "_busy_low"}, 144'(busySig), 144'(0));
    endtask

    logic [9*DW-1:0] allOnes;

    initial begin
        rst = 1'b0;
        start = 1'b0;
        cfgWe = 1'b0;
        cfgAddr = '0;
        cfgData = '0;
        inValid = 1'b0;
        inData = '0;
        outReady = 1'b1;
        allOnes = {9{FX_ONE}};

        tick;
        tick;
        checkOutput("rst_in_ready", 144'(inReady), 144'(0));
        checkOutput("rst_out_valid", 144'(outValid), 144'(0));
        checkOutput("rst_out_data", 144'(outData), 144'(0));
        checkOutput("rst_mac_d", macD, 144'(0));
        checkOutput("rst_mac_w", macW, 144'(0));
        checkOutput("rst_mac_b", 144'(macB), 144'(0));
        checkOutput("rst_busy", 144'(busySig), 144'(0));
        checkOutput("rst_done", 144'(doneSig), 144'(0));
        rst = 1'b1;
        tick;

        $display("[TB] centre-tap frame 4x4");
        sel = 0;
        loadWeights(1'b1, '0);
        applyStimulus(16, 1, -1, 0, -1, -1);
        checkOutput("t1_busy_drain", 144'(busySig), 144'(1));
        checkOutput("t1_in_ready_drain", 144'(inReady), 144'(0));
        expV = '{6, 7, 10, 11, 0, 0, 0, 0};
        expectResults("t1", 4);
        checkOutput("t1_latency", 144'(firstValidCyc - acc[10]), 144'(3));

        $display("[TB] all-ones frame with bias");
        loadWeights(1'b0, FX_ONE);
        writeCfg(4'd12, 16'hBEEF);
        checkOutput("t2_mac_w", macW, allOnes);
        checkOutput("t2_mac_b", 144'(macB), 144'(FX_ONE));
        applyStimulus(16, 1, -1, 0, -1, -1);
        expV = '{55, 64, 91, 100, 0, 0, 0, 0};
        expectResults("t2", 4);

        $display("[TB] cfg and start pulses during RUN");
        applyStimulus(16, 1, -1, 0, 5, -1);
        expectResults("t3", 4);
        checkOutput("t3_mac_w_kept", macW, allOnes);
        checkOutput("t3_mac_b_kept", 144'(macB), 144'(FX_ONE));

        $display("[TB] reset mid-frame");
        loadWeights(1'b1, '0);
        applyStimulus(16, 1, -1, 0, -1, 7);
        rst = 1'b0;
        tick;
        checkOutput("t4_in_ready", 144'(inReady), 144'(0));
        checkOutput("t4_out_valid", 144'(outValid), 144'(0));
        checkOutput("t4_out_data", 144'(outData), 144'(0));
        checkOutput("t4_mac_d", macD, 144'(0));
        checkOutput("t4_mac_w", macW, 144'(0));
        checkOutput("t4_mac_b", 144'(macB), 144'(0));
        checkOutput("t4_busy", 144'(busySig), 144'(0));
        checkOutput("t4_done", 144'(doneSig), 144'(0));
        rst = 1'b1;
        tick;
        loadWeights(1'b1, '0);
        applyStimulus(16, 1, -1, 0, -1, -1);
        expV = '{6, 7, 10, 11, 0, 0, 0, 0};
        expectResults("t4", 4);

        $display("[TB] backpressure on 6x4 frame");
        resetAll;
        sel = 2;
        loadWeights(1'b0, FX_ONE);
        applyStimulus(24, 1, 12, 10, -1, -1);
        checkOutput("t5_in_ready_dropped", 144'(sawDrop), 144'(1));
        expV = '{73, 82, 91, 100, 127, 136, 145, 154};
        expectResults("t5", 8);

        $display("[TB] back-to-back 5x3 frames");
        resetAll;
        sel = 1;
        loadWeights(1'b0, '0);
        applyStimulus(15, 1, -1, 0, -1, -1);
        expV = '{63, 72, 81, 0, 0, 0, 0, 0};
        expectResults("t6a", 3);
        applyStimulus(15, 11, -1, 0, -1, -1);
        expV = '{153, 162, 171, 0, 0, 0, 0, 0};
        expectResults("t6b", 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
